// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential shift unit.
package shift_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between an operand source and the shift sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AW-1:0]    amount;
    logic             direction;
    logic             arithmetic;
    logic             rotate;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, operand, amount, direction, arithmetic, rotate,
        input  result, carry, busy, done
    );

    modport slave (
        input  start, operand, amount, direction, arithmetic, rotate,
        output result, carry, busy, done
    );
endinterface

// File: rtl/shift_step_1b.sv
// Combinational one-bit shift step: left, logical/arithmetic right, and
// rotate when SHIFT_ROTATE_EN is defined.
module shift_step_1b
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             direction_i,
    input  logic             arithmetic_i,
    input  logic             rotate_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_out_o
);
    logic fill;

    always_comb begin
        fill      = 1'b0;
        data_o    = data_i;
        bit_out_o = 1'b0;
        if (direction_i == DIR_LEFT) begin
`ifdef SHIFT_ROTATE_EN
            fill = rotate_i ? data_i[WIDTH-1] : 1'b0;
`endif
            data_o    = {data_i[WIDTH-2:0], fill};
            bit_out_o = data_i[WIDTH-1];
        end else begin
            fill = arithmetic_i & data_i[WIDTH-1];
`ifdef SHIFT_ROTATE_EN
            // Rotate overrides sign fill.
            if (rotate_i) fill = data_i[0];
`endif
            data_o    = {fill, data_i[WIDTH-1:1]};
            bit_out_o = data_i[0];
        end
    end

`ifndef SHIFT_ROTATE_EN
    logic unused_rotate;
    assign unused_rotate = rotate_i;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer issuing one-bit shift steps per clock; rotate mode is built only
// when SHIFT_ROTATE_EN is defined.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [AW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             dir_q;
    logic             arith_q;
    logic             rot_q;
    logic             done_q;
    logic             accept;

    assign accept = (state_q != SHIFT) && bus.start;

`ifdef SHIFT_ROTATE_EN
    always_ff @(posedge clk) begin
        if (reset)       rot_q <= 1'b0;
        else if (accept) rot_q <= bus.rotate;
    end
`else
    logic unused_rotate;
    assign unused_rotate = bus.rotate;
    assign rot_q = 1'b0;
`endif

    shift_step_1b #(.WIDTH(WIDTH)) u_step (
        .data_i       (work_q),
        .direction_i  (dir_q),
        .arithmetic_i (arith_q),
        .rotate_i     (rot_q),
        .data_o       (work_d),
        .bit_out_o    (carry_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        work_q  <= bus.operand;
                        dir_q   <= bus.direction;
                        arith_q <= bus.arithmetic;
                        cnt_q   <= bus.amount;
                        carry_q <= 1'b0;
                        if (bus.amount != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q  <= work_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q - AW'(1);
                    // The step taken with the count at 1 is the last one.
                    if (cnt_q == AW'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // busy also covers the acceptance cycle of a non-zero shift.
    assign bus.busy   = (state_q == SHIFT) || (accept && (bus.amount != '0));
    assign bus.result = work_q;
    assign bus.carry  = carry_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed requests push expected
// result/carry/done-cycle; a negedge monitor pops on every done pulse.
module tb_shift_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q[$];

    shift_sequencer_if #(.WIDTH(8)) bus();

    shift_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_result"}, 32'(bus.result), 32'(e.res));
                chk({e.name, "_carry"},  32'(bus.carry),  32'(e.c));
                chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at posedge+1: drives a request accepted at the next edge.
    task automatic launch(input string name, input logic [7:0] op, input logic [2:0] amt,
                          input logic dir, input logic ar, input logic rot,
                          input logic [7:0] eres, input logic ec);
        exp_t e;
        bus.start      = 1'b1;
        bus.operand    = op;
        bus.amount     = amt;
        bus.direction  = dir;
        bus.arithmetic = ar;
        bus.rotate     = rot;
        e.res  = eres;
        e.c    = ec;
        e.cyc  = cyc + 1 + int'(amt);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            next_slot();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
        next_slot();
    endtask

    task automatic request(input string name, input logic [7:0] op, input logic [2:0] amt,
                           input logic dir, input logic ar, input logic rot,
                           input logic [7:0] eres, input logic ec);
        next_slot();
        launch(name, op, amt, dir, ar, rot, eres, ec);
        next_slot();
        bus.start = 1'b0;
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.operand    = '0;
        bus.amount     = '0;
        bus.direction  = 1'b0;
        bus.arithmetic = 1'b0;
        bus.rotate     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_result", 32'(bus.result), 32'h0);
            chk("reset_carry",  32'(bus.carry),  32'h0);
            chk("reset_busy",   32'(bus.busy),   32'h0);
            chk("reset_done",   32'(bus.done),   32'h0);
        end

        request("left3", 8'b1011_0011, 3'd3, 1'b0, 1'b0, 1'b0, 8'b1001_1000, 1'b1);
        repeat (3) next_slot();
        chk("left3_hold", 32'(bus.result), 32'h98);

        request("asr2", 8'b1011_0011, 3'd2, 1'b1, 1'b1, 1'b0, 8'b1110_1100, 1'b1);
        request("lsr2", 8'b1011_0011, 3'd2, 1'b1, 1'b0, 1'b0, 8'b0010_1100, 1'b1);

        // amount 0, then back-to-back start in the DONE cycle
        next_slot();
        launch("amt0", 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        #1;
        chk("amt0_busy", 32'(bus.busy), 32'h0);
        next_slot();
        chk("amt0_done_now", 32'(bus.done), 32'h1);
        launch("b2b_left1", 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1);
        #1;
        chk("b2b_busy", 32'(bus.busy), 32'h1);
        next_slot();
        bus.start = 1'b0;
        drain();

`ifdef SHIFT_ROTATE_EN
        request("ror1", 8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b1);
`else
        request("ror1", 8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 8'h40, 1'b1);
`endif

        // Abort: long shift, ignored second start, reset wins over start.
        next_slot();
        bus.start = 1'b1; bus.operand = 8'hFF; bus.amount = 3'd7;
        bus.direction = 1'b0; bus.arithmetic = 1'b0; bus.rotate = 1'b0;
        next_slot();
        bus.start = 1'b0;
        chk("abort_busy_c1", 32'(bus.busy), 32'h1);
        next_slot();
        bus.start = 1'b1; bus.operand = 8'h0F; bus.amount = 3'd1;
        #1;
        chk("abort_busy_c2", 32'(bus.busy), 32'h1);
        next_slot();
        bus.start = 1'b0;
        next_slot();
        reset = 1'b1;
        bus.start = 1'b1; bus.operand = 8'h55; bus.amount = 3'd0;
        next_slot();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("abort_result", 32'(bus.result), 32'h0);
        chk("abort_carry",  32'(bus.carry),  32'h0);
        chk("abort_busy",   32'(bus.busy),   32'h0);
        chk("abort_done",   32'(bus.done),   32'h0);
        repeat (12) next_slot();
        chk("abort_idle_result", 32'(bus.result), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
